// File: rtl/loom_dpi_call_bridge_if.sv
// Register-file side of one DPI function slot: call request and return handshakes.
// master = call bridge (initiator), slave = DPI register file slot.
interface loom_dpi_call_bridge_if #(
   parameter int unsigned MAX_ARGS = 8
);
   logic                         call_valid;
   logic                         call_ready;
   logic [MAX_ARGS*32-1:0]       call_args;
   logic                         ret_valid;
   logic                         ret_ready;
   logic [64+MAX_ARGS*32-1:0]    ret_data;

   modport master (
      output call_valid, call_args, ret_ready,
      input  call_ready, ret_valid, ret_data
   );

   modport slave (
      input  call_valid, call_args, ret_ready,
      output call_ready, ret_valid, ret_data
   );
endinterface

// File: rtl/loom_dpi_call_bridge.sv
// DUT-side initiator for one DPI function: latches call arguments, runs the call/return
// handshakes with the register file and stalls the DUT until the result is delivered.
// Optional WAIT-state timeout with stale-return draining: define LOOM_DPI_CALL_TIMEOUT_EN.
module loom_dpi_call_bridge #(
   parameter int unsigned ARG_WIDTH      = 64,
   parameter int unsigned MAX_ARGS       = 8,
   parameter int unsigned RET_WIDTH      = 32,
   parameter int unsigned OUT_WIDTH      = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       dut_call_i,
   input  logic [ARG_WIDTH-1:0]                       dut_args_i,
   output logic                                       dut_stall_o,
   output logic                                       dut_ret_valid_o,
   output logic [RET_WIDTH-1:0]                       dut_ret_o,
   output logic [((OUT_WIDTH > 0) ? OUT_WIDTH : 1)-1:0] dut_out_o,
   loom_dpi_call_bridge_if.master                     rf,
   output logic [31:0]                                call_count_o,
   output logic                                       overrun_o,
   output logic                                       timeout_o
);

   localparam int unsigned OutW   = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
   localparam int unsigned ArgBus = MAX_ARGS * 32;

   if (ARG_WIDTH < 1 || ARG_WIDTH > ArgBus) begin : g_bad_arg_width
      $error("ARG_WIDTH must be within 1..MAX_ARGS*32");
   end
   if (RET_WIDTH < 1 || RET_WIDTH > 64) begin : g_bad_ret_width
      $error("RET_WIDTH must be within 1..64");
   end
   if (OUT_WIDTH > ArgBus) begin : g_bad_out_width
      $error("OUT_WIDTH must be within 0..MAX_ARGS*32");
   end

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e               state_q, state_d;
   logic [ArgBus-1:0]    args_q, args_d;
   logic [RET_WIDTH-1:0] ret_q, ret_d;
   logic [OutW-1:0]      out_q, out_d;
   logic [31:0]          count_q, count_d;
   logic                 overrun_q, overrun_d;
   logic [OutW-1:0]      out_cap;
   logic                 timeout_hit;
   logic                 drain;
   logic                 unused_ret_data;

   // Bits of the return bus beyond the scalar result and output array are don't-care.
   assign unused_ret_data = ^rf.ret_data;

   if (OUT_WIDTH > 0) begin : g_out
      assign out_cap = rf.ret_data[64 +: OUT_WIDTH];
   end else begin : g_no_out
      assign out_cap = '0;
   end

`ifdef LOOM_DPI_CALL_TIMEOUT_EN
   logic [31:0] tmo_cnt_q, tmo_cnt_d;
   logic        stale_q, stale_d;
   logic        timeout_q, timeout_d;

   assign timeout_hit = (state_q == StWait) && !rf.ret_valid
                        && (tmo_cnt_q == TIMEOUT_CYCLES - 1);
   // A return that arrives after we gave up must still be acked to free the slot.
   assign drain       = stale_q && (state_q != StWait) && rf.ret_valid;
   assign timeout_o   = timeout_q;

   // Timeout counter, stale-return tracking and sticky timeout flag.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      stale_d   = stale_q;
      timeout_d = timeout_q;
      if (state_q == StReq && rf.call_ready) begin
         tmo_cnt_d = '0;
      end else if (state_q == StWait) begin
         tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
      if (timeout_hit) begin
         stale_d   = 1'b1;
         timeout_d = 1'b1;
      end else if (drain) begin
         stale_d = 1'b0;
      end
   end

   // Timeout state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
         stale_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         stale_q   <= stale_d;
         timeout_q <= timeout_d;
      end
   end
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
   assign drain       = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   // Call FSM next state, argument latch, result capture and counters.
   always_comb begin
      state_d   = state_q;
      args_d    = args_q;
      ret_d     = ret_q;
      out_d     = out_q;
      count_d   = count_q;
      overrun_d = overrun_q | (dut_call_i && (state_q != StIdle));
      unique case (state_q)
         StIdle: begin
            if (dut_call_i) begin
               args_d                = '0;
               args_d[ARG_WIDTH-1:0] = dut_args_i;
               state_d               = StReq;
            end
         end
         StReq: begin
            if (rf.call_ready) state_d = StWait;
         end
         StWait: begin
            if (rf.ret_valid) begin
               ret_d   = rf.ret_data[RET_WIDTH-1:0];
               out_d   = out_cap;
               state_d = StResp;
            end else if (timeout_hit) begin
               ret_d   = '0;
               out_d   = '0;
               state_d = StResp;
            end
         end
         StResp: begin
            count_d = count_q + 32'd1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset returns to IDLE mid-call.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         args_q    <= '0;
         ret_q     <= '0;
         out_q     <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         args_q    <= args_d;
         ret_q     <= ret_d;
         out_q     <= out_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Outputs decoded from registered state only (ret_ready may follow ret_valid while draining).
   always_comb begin
      rf.call_valid   = (state_q == StReq);
      rf.call_args    = args_q;
      rf.ret_ready    = (state_q == StWait) || drain;
      dut_stall_o     = (state_q == StReq) || (state_q == StWait);
      dut_ret_valid_o = (state_q == StResp);
      dut_ret_o       = ret_q;
      dut_out_o       = out_q;
      call_count_o    = count_q;
      overrun_o       = overrun_q;
   end

endmodule

// File: tb/tb_loom_dpi_call_bridge.sv
// Directed, table-driven bench for loom_dpi_call_bridge (ARG_WIDTH=40, RET_WIDTH=16,
// OUT_WIDTH=32, TIMEOUT_CYCLES=16). Timeout sequence runs when LOOM_DPI_CALL_TIMEOUT_EN is set.
module tb_loom_dpi_call_bridge;

   logic        clk;
   logic        rst_n;
   logic        dut_call;
   logic [39:0] dut_args;
   logic        dut_stall;
   logic        dut_ret_valid;
   logic [15:0] dut_ret;
   logic [31:0] dut_out;
   logic [31:0] call_count;
   logic        overrun;
   logic        timeout;

   int n_checks;
   int n_fail;
   logic [31:0] exp_count;

   loom_dpi_call_bridge_if #(.MAX_ARGS(8)) rf_if ();

   loom_dpi_call_bridge #(
      .ARG_WIDTH     (40),
      .MAX_ARGS      (8),
      .RET_WIDTH     (16),
      .OUT_WIDTH     (32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .dut_call_i     (dut_call),
      .dut_args_i     (dut_args),
      .dut_stall_o    (dut_stall),
      .dut_ret_valid_o(dut_ret_valid),
      .dut_ret_o      (dut_ret),
      .dut_out_o      (dut_out),
      .rf             (rf_if),
      .call_count_o   (call_count),
      .overrun_o      (overrun),
      .timeout_o      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [39:0] args;
      logic [63:0] ret_lo;
      logic [31:0] out_w;
      int          rdy_dly;
      int          ret_dly;
      logic [15:0] exp_ret;
      logic [31:0] exp_out;
      logic [31:0] exp_w0;
      logic [31:0] exp_w1;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full call; poke pulses dut_call_i during the first WAIT cycle.
   task automatic do_call(input vec_t v, input bit poke);
      logic [255:0] ca;
      dut_call = 1'b1;
      dut_args = v.args;
      tick();
      dut_call = 1'b0;
      dut_args = '0;
      ca = rf_if.call_args;
      check("req_call_valid", rf_if.call_valid, 1);
      check("req_stall", dut_stall, 1);
      check("args_word0", ca[31:0], v.exp_w0);
      check("args_word1", ca[63:32], v.exp_w1);
      for (int k = 2; k < 8; k++) check("args_upper_zero", ca[32*k +: 32], 0);
      for (int i = 0; i < v.rdy_dly; i++) begin
         tick();
         check("req_valid_held", rf_if.call_valid, 1);
         check("req_stall_held", dut_stall, 1);
      end
      rf_if.call_ready = 1'b1;
      tick();
      rf_if.call_ready = 1'b0;
      check("wait_valid_dropped", rf_if.call_valid, 0);
      check("wait_stall", dut_stall, 1);
      check("wait_ret_ready", rf_if.ret_ready, 1);
      if (poke) begin
         dut_call = 1'b1;
         tick();
         dut_call = 1'b0;
         check("poke_no_second_req", rf_if.call_valid, 0);
         check("poke_overrun", overrun, 1);
         check("poke_still_waiting", dut_stall, 1);
      end
      for (int i = 0; i < v.ret_dly; i++) begin
         tick();
         check("wait_stall_held", dut_stall, 1);
         check("wait_no_result", dut_ret_valid, 0);
      end
      rf_if.ret_valid = 1'b1;
      rf_if.ret_data  = {{7{32'h5A5A_A5A5}}, v.out_w, v.ret_lo};
      tick();
      rf_if.ret_valid = 1'b0;
      rf_if.ret_data  = '0;
      check("resp_pulse", dut_ret_valid, 1);
      check("resp_ret", dut_ret, v.exp_ret);
      check("resp_out", dut_out, v.exp_out);
      check("resp_stall_low", dut_stall, 0);
      check("resp_ret_ready_low", rf_if.ret_ready, 0);
      exp_count = exp_count + 32'd1;
      tick();
      check("idle_pulse_gone", dut_ret_valid, 0);
      check("idle_count", call_count, exp_count);
      check("idle_ret_held", dut_ret, v.exp_ret);
      check("idle_out_held", dut_out, v.exp_out);
      check("idle_no_req", rf_if.call_valid, 0);
      check("idle_stall_low", dut_stall, 0);
   endtask

   initial begin
      vec_t pv;
      n_checks  = 0;
      n_fail    = 0;
      exp_count = '0;

      //          args               ret_lo                  out_w         rdy ret exp_ret   exp_out       w0            w1
      vecs[0] = '{40'hAB_1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 32'h1122_3344, 0,  3, 16'hF00D, 32'h1122_3344, 32'h1234_5678, 32'h0000_00AB};
      vecs[1] = '{40'hFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF, 32'hFFFF_FFFF, 2,  0, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
      vecs[2] = '{40'h00_0000_0000, 64'h1234_5678_0000_0001, 32'h0000_0000, 1,  1, 16'h0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{40'h01_8000_0001, 64'h0000_0000_8765_4321, 32'hA0B0_C0D0, 10, 2, 16'h4321, 32'hA0B0_C0D0, 32'h8000_0001, 32'h0000_0001};

      rst_n            = 1'b0;
      dut_call         = 1'b0;
      dut_args         = '0;
      rf_if.call_ready = 1'b0;
      rf_if.ret_valid  = 1'b0;
      rf_if.ret_data   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_call_valid", rf_if.call_valid, 0);
      check("rst_call_args", rf_if.call_args[63:0], 0);
      check("rst_ret_ready", rf_if.ret_ready, 0);
      check("rst_stall", dut_stall, 0);
      check("rst_ret_valid", dut_ret_valid, 0);
      check("rst_ret", dut_ret, 0);
      check("rst_out", dut_out, 0);
      check("rst_count", call_count, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout, 0);
      rst_n = 1'b1;
      tick();

      // Return offered outside WAIT must be ignored.
      rf_if.ret_valid = 1'b1;
      #1;
      check("idle_ret_ignored", rf_if.ret_ready, 0);
      tick();
      rf_if.ret_valid = 1'b0;
      check("idle_ret_no_state", dut_ret_valid, 0);

      for (int i = 0; i < 4; i++) begin
         do_call(vecs[i], 1'b0);
         check("no_overrun_yet", overrun, 0);
      end

      // Call arriving while a call is in flight: dropped and flagged.
      pv = vecs[2];
      do_call(pv, 1'b1);
      tick();
      check("overrun_sticky", overrun, 1);
      check("overrun_count_once", call_count, exp_count);
      check("overrun_no_req", rf_if.call_valid, 0);

      // Counter wrap at 0xFFFFFFFF.
      force dut.count_q = 32'hFFFF_FFFF;
      tick();
      release dut.count_q;
      exp_count = 32'hFFFF_FFFF;
      check("preload_count", call_count, 32'hFFFF_FFFF);
      do_call(vecs[0], 1'b0);
      check("wrap_count_zero", call_count, 0);

`ifdef LOOM_DPI_CALL_TIMEOUT_EN
      // No return: RESP 16 cycles after WAIT entry with zeroed result, then drain the late ack.
      dut_call = 1'b1;
      dut_args = 40'h12_3456_789A;
      tick();
      dut_call         = 1'b0;
      rf_if.call_ready = 1'b1;
      tick();
      rf_if.call_ready = 1'b0;
      for (int i = 1; i < 16; i++) begin
         tick();
         check("tmo_still_waiting", dut_stall, 1);
         check("tmo_no_result", dut_ret_valid, 0);
      end
      tick();
      check("tmo_resp_pulse", dut_ret_valid, 1);
      check("tmo_ret_zero", dut_ret, 0);
      check("tmo_out_zero", dut_out, 0);
      check("tmo_flag", timeout, 1);
      exp_count = exp_count + 32'd1;
      tick();
      check("tmo_idle", dut_stall, 0);
      check("tmo_count", call_count, exp_count);
      rf_if.ret_valid = 1'b1;
      rf_if.ret_data  = {{8{32'h0BAD_0BAD}}, 64'h0BAD_0BAD_0BAD_0BAD};
      #1;
      check("drain_ack", rf_if.ret_ready, 1);
      tick();
      check("drain_once", rf_if.ret_ready, 0);
      check("drain_no_result", dut_ret_valid, 0);
      rf_if.ret_valid = 1'b0;
      rf_if.ret_data  = '0;
      do_call(vecs[1], 1'b0);
      check("tmo_flag_sticky", timeout, 1);
`else
      check("timeout_tied_low", timeout, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
